// File: rtl/ama_riscv_uart_tx_if.sv
// rv_if: generic ready/valid channel.
//
// Handshake contract: the producer drives valid/data, and the consumer drives ready.
// A transfer happens on each rising clock edge where valid && ready.
// The consumer may compute ready without looking at valid.
//
// Modports:
//   TX - producer side (valid, data out; ready in)
//   RX - consumer side (valid, data in; ready out)
interface rv_if #(
  parameter int DW = 8
);
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport TX (output valid, output data, input ready);
  modport RX (input valid, input data, output ready);
endinterface

// File: rtl/ama_riscv_uart_tx.sv
// ama_riscv_uart_tx: memory-mapped UART transmitter.
//
// Bytes arrive from the core's store path on a ready/valid channel and are
// buffered in a small power-of-two FIFO. Each byte is then sent as one 8N1 frame:
// a start bit, 8 data bits LSB-first, and a stop bit.
// Back-to-back frames have no idle gap between them.
//
// Ports:
//   clk       - core clock; all state changes on its rising edge
//   rst       - synchronous active-high reset; aborts any frame in flight
//   send      - rv_if.RX byte input (valid/data in, ready out)
//   tx        - serial line, idle high, driven straight from a flop
//   tx_ready  - FIFO not full (same signal as send.ready)
//   busy      - a frame is in flight or bytes are still buffered
//   level     - FIFO occupancy, 0..FIFO_DEPTH
//   state_dbg - current transmit FSM state, for observation only

package ama_riscv_uart_pkg;

  typedef enum int unsigned {
    BR_9600   = 9600,
    BR_19200  = 19200,
    BR_38400  = 38400,
    BR_57600  = 57600,
    BR_115200 = 115200,
    BR_230400 = 230400,
    BR_460800 = 460800,
    BR_921600 = 921600
  } uart_baud_rate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

module ama_riscv_uart_tx
  import ama_riscv_uart_pkg::*;
#(
  parameter int unsigned     CLK_FREQ_HZ = 100_000_000,
  parameter uart_baud_rate_t BAUD_RATE   = BR_115200,
  parameter int unsigned     FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  rv_if.RX                            send,
  output logic                        tx,
  output logic                        tx_ready,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output uart_tx_state_t              state_dbg
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / int'(BAUD_RATE);
  localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W        = PTR_W + 1;

  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("ama_riscv_uart_tx: FIFO_DEPTH must be a power of two");
  end

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("ama_riscv_uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  // ready depends only on the registered level, so valid never reaches an output.
  assign tx_ready   = (level_q != LVL_W'(FIFO_DEPTH));
  assign send.ready = tx_ready;
  assign push       = send.valid && tx_ready;
  assign fifo_empty = (level_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= send.data[7:0];
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  uart_tx_state_t    state_q, state_d;
  logic              tx_q, tx_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // tx is computed one cycle ahead, so the flop output changes exactly at each bit boundary.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr];
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          baud_d  = '0;
          tx_d    = shreg_q[0];
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q != 3'd7) begin
            // shreg_q[1] becomes bit 0 once the shift lands.
            tx_d  = shreg_q[1];
            bit_d = bit_q + 3'd1;
          end else begin
            tx_d    = 1'b1;
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit with no idle cycle.
            pop     = 1'b1;
            shreg_d = mem[rd_ptr];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign level     = level_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ama_riscv_uart_tx.sv
// tb_ama_riscv_uart_tx: directed bench for ama_riscv_uart_tx.
// CLK_FREQ_HZ=460800 and BR_115200 give 4 clocks per bit.
// A line monitor decodes every frame and compares it with the expected-byte queue.
// The main sequence checks cycle-exact timing, FIFO status and reset behaviour.
module tb_ama_riscv_uart_tx;
  import ama_riscv_uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #(200_000 * 10);
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  logic           tx;
  logic           tx_ready;
  logic           busy;
  logic [2:0]     level;
  uart_tx_state_t state_dbg;

  rv_if #(.DW(8)) send_if ();

  ama_riscv_uart_tx #(
    .CLK_FREQ_HZ(460800),
    .BAUD_RATE  (BR_115200),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .send     (send_if),
    .tx       (tx),
    .tx_ready (tx_ready),
    .busy     (busy),
    .level    (level),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         mon_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a negedge. Returns just after the negedge that follows the
  // handshake edge, with valid still high so that pushes can run back-to-back.
  task automatic push_byte(input logic [7:0] b, output int waited);
    waited = 0;
    send_if.valid = 1'b1;
    send_if.data  = b;
    while (tx_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("push_ready_0x%02h", b), 32'(tx_ready), 32'd1);
    exp_q.push_back(b);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    send_if.valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- line monitor ----------------
  // Detects the first low cycle of a start bit and samples each bit one cycle in.
  // Aborts silently if reset is seen mid-frame.
  initial begin : monitor
    logic [9:0] bits;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (mon_en && rst === 1'b0 && tx === 1'b0) begin
        start_q.push_back(cyc);
        aborted = 1'b0;
        bits    = '0;
        for (int b = 0; b < 10; b++) begin
          if (!aborted) begin
            for (int w = 0; w < ((b == 0) ? (CPB / 2 - 1) : CPB); w++) begin
              @(negedge clk);
              if (rst !== 1'b0) aborted = 1'b1;
            end
            bits[b] = tx;
          end
        end
        if (!aborted) begin
          check("mon_start_bit", 32'(bits[0]), 32'd0);
          check("mon_stop_bit", 32'(bits[9]), 32'd1);
          check("mon_frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("mon_byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  logic [9:0] a5_frame;
  logic [7:0] wrap_bytes[12];

  initial begin : stimulus
    int w;
    int wsum;
    int lows;
    int busys;
    int g;

    send_if.valid = 1'b0;
    send_if.data  = 8'h00;
    a5_frame      = 10'b11_0100_1010;  // stop, A5 MSB..LSB, start
    wrap_bytes    = '{8'h00, 8'hFF, 8'h80, 8'h01, 8'h55, 8'hAA,
                      8'h7F, 8'hFE, 8'h3C, 8'hC3, 8'h69, 8'h96};

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0xA5: handshake at edge N
    push_byte(8'hA5, w);
    idle();
    check("a5_n1_tx", 32'(tx), 32'd1);
    check("a5_n1_level", 32'(level), 32'd1);
    check("a5_n1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("a5_n2_tx_fall", 32'(tx), 32'd0);
    check("a5_n2_level", 32'(level), 32'd0);
    for (int j = 1; j < FRAME; j++) begin
      @(negedge clk);
      check($sformatf("a5_tx_cycle%0d", j), 32'(tx), 32'(a5_frame[j / CPB]));
    end
    check("a5_last_stop_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("a5_after_busy", 32'(busy), 32'd0);
    check("a5_after_tx", 32'(tx), 32'd1);
    check("a5_after_state", 32'(state_dbg), 32'(IDLE));
    wait_idle(100, "a5_drain");

    // Full FIFO: 0x01..0x05 with valid held
    start_q.delete();
    wsum = 0;
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i), w);
      wsum += w;
    end
    check("burst_no_stall", 32'(wsum), 32'd0);
    check("burst_level_peak", 32'(level), 32'd4);
    check("burst_ready_low", 32'(tx_ready), 32'd0);
    check("burst_busy", 32'(busy), 32'd1);
    // valid held with ready low must be ignored
    send_if.valid = 1'b1;
    send_if.data  = 8'hEE;
    repeat (36) @(negedge clk);
    check("full_hold_level", 32'(level), 32'd4);
    check("full_hold_ready", 32'(tx_ready), 32'd0);
    idle();
    @(negedge clk);
    check("full_pop_level", 32'(level), 32'd3);
    check("full_pop_ready", 32'(tx_ready), 32'd1);
    wait_idle(400, "burst_drain");
    check("burst_frames", 32'(start_q.size()), 32'd5);
    for (int i = 1; i < start_q.size(); i++) begin
      check($sformatf("burst_gap%0d", i), 32'(start_q[i] - start_q[i - 1]), 32'(FRAME));
    end
    check("burst_queue_empty", 32'(exp_q.size()), 32'd0);

    // Simultaneous push and pop: idle pop, then stop-bit pop
    push_byte(8'hC3, w);
    check("sim_n1_level", 32'(level), 32'd1);
    push_byte(8'h5A, w);
    idle();
    check("sim_idle_pop_level", 32'(level), 32'd1);
    check("sim_idle_pop_tx", 32'(tx), 32'd0);
    repeat (39) @(negedge clk);
    check("sim_stop_level", 32'(level), 32'd1);
    check("sim_stop_tx", 32'(tx), 32'd1);
    push_byte(8'h96, w);
    idle();
    check("sim_stop_pop_level", 32'(level), 32'd1);
    check("sim_back_to_back_tx", 32'(tx), 32'd0);
    wait_idle(400, "sim_drain");
    check("sim_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame during data bit 3 with 2 bytes buffered
    push_byte(8'h3C, w);
    push_byte(8'h81, w);
    push_byte(8'h7E, w);
    idle();
    repeat (16) @(negedge clk);
    check("mid_state_data", 32'(state_dbg), 32'(DATA));
    check("mid_level", 32'(level), 32'd2);
    check("mid_tx_bit3", 32'(tx), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    lows  = 0;
    busys = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    check("mid_no_frames_tx", 32'(lows), 32'd0);
    check("mid_no_frames_busy", 32'(busys), 32'd0);

    // Wrap-around: 12 bytes with random valid gaps
    start_q.delete();
    for (int i = 0; i < 12; i++) begin
      g = int'($urandom_range(0, 3));
      if (g > 0) begin
        idle();
        repeat (g) @(negedge clk);
      end
      push_byte(wrap_bytes[i], w);
    end
    idle();
    wait_idle(1500, "wrap_drain");
    check("wrap_frames", 32'(start_q.size()), 32'd12);
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
    check("wrap_end_level", 32'(level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
